shishi_bit_count: RTL and testbench

- Registered bit-counting unit for the P7 datapath.
- Takes a 32-bit operand `A` and returns one of four bit statistics on `cnt`, one clock after the request is accepted.
- Statistics: population count, leading zeros, trailing zeros, leading ones.
- Intended as a single-cycle-latency functional unit beside the ALU/MD unit in the EX stage.

---
 rtl/shishi_pkg.sv | 11 +
 rtl/lzc_core.sv | 21 ++
 rtl/shishi_bit_count.sv | 85 ++++++++
 tb/tb_shishi_bit_count.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/shishi_pkg.sv
// Shared encodings and widths for the shishi bit-count unit.
package shishi_pkg;

    localparam logic [1:0] OP_POP = 2'b00;
    localparam logic [1:0] OP_CLZ = 2'b01;
    localparam logic [1:0] OP_CTZ = 2'b10;
    localparam logic [1:0] OP_CLO = 2'b11;

    localparam int CNT_W = 32;

endpackage

// File: rtl/lzc_core.sv
// Leading-zero counter: number of consecutive zeros from the MSB; all-zero input gives WIDTH.
module lzc_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         data,
    output logic [$clog2(WIDTH):0]   zcnt
);

    localparam int CW = $clog2(WIDTH) + 1;

    // Ascending scan: the highest set bit is the last to write, so it wins.
    always_comb begin
        zcnt = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                zcnt = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/shishi_bit_count.sv
// Registered bit-statistics unit: popcount, clz, ctz, clo with one-cycle latency.
module shishi_bit_count
    import shishi_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   A,
    output logic [CNT_W-1:0]   cnt,
    output logic               out_valid
);

    localparam int LV = $clog2(WIDTH);
    localparam int CW = LV + 1;

    logic [WIDTH-1:0] a_rev;
    logic [WIDTH-1:0] lz_in;
    logic [CW-1:0]    lz_cnt;
    logic [CW-1:0]    pop_cnt;
    logic [CW-1:0]    res;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign a_rev[i] = A[WIDTH-1-i];
    end

    // Popcount adder tree: level l holds WIDTH>>l partial sums.
    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        localparam int N = WIDTH >> l;
        logic [CW-1:0] s [N];
        for (genvar j = 0; j < N; j++) begin : g_node
            if (l == 0) begin : g_leaf
                assign s[j] = {{(CW-1){1'b0}}, A[j]};
            end else begin : g_add
                assign s[j] = g_lvl[l-1].s[2*j] + g_lvl[l-1].s[2*j+1];
            end
        end
    end

    assign pop_cnt = g_lvl[LV].s[0];

    // One shared leading-zero encoder: clo = clz(~A), ctz = clz(reverse(A)).
    always_comb begin
        lz_in = A;
        case (op)
            OP_CLO:  lz_in = ~A;
            OP_CTZ:  lz_in = a_rev;
            default: lz_in = A;
        endcase
    end

    lzc_core #(.WIDTH(WIDTH)) u_lzc (
        .data (lz_in),
        .zcnt (lz_cnt)
    );

    always_comb begin
        res = lz_cnt;
        if (op == OP_POP) begin
            res = pop_cnt;
        end
        cnt_d = CNT_W'(res);
    end

    // cnt holds when idle so downstream bypass muxes see no toggling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                cnt_q <= cnt_d;
            end
        end
    end

    assign cnt       = cnt_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_shishi_bit_count.sv
// Directed scoreboard bench for shishi_bit_count.
module tb_shishi_bit_count;
    import shishi_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] cnt;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_cnt;

    shishi_bit_count #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .op        (op),
        .A         (A),
        .cnt       (cnt),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a);
        int n;
        n = 0;
        case (o)
            2'b00: for (int i = 0; i < 32; i++) n += int'(a[i]);
            2'b01: begin
                for (int i = 31; i >= 0; i--) begin
                    if (a[i]) break;
                    n++;
                end
            end
            2'b10: begin
                for (int i = 0; i < 32; i++) begin
                    if (a[i]) break;
                    n++;
                end
            end
            default: begin
                for (int i = 31; i >= 0; i--) begin
                    if (!a[i]) break;
                    n++;
                end
            end
        endcase
        return 32'(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare the registered output against the scoreboard after an edge.
    task automatic check_out(input string tag);
        logic [31:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
            chk({tag, "_cnt"}, cnt, e);
            last_cnt = e;
        end else begin
            chk({tag, "_idle_valid"}, {31'b0, out_valid}, 32'd0);
            chk({tag, "_hold_cnt"}, cnt, last_cnt);
        end
    endtask

    task automatic req(input string tag, input logic v, input logic [1:0] o, input logic [31:0] a);
        @(negedge clk);
        in_valid = v;
        op       = o;
        A        = a;
        if (v) exp_q.push_back(model(o, a));
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b1;
        op       = OP_POP;
        A        = 32'd33;
        last_cnt = 32'd0;

        // Reset held with a live request: outputs stay cleared.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rst_cnt", cnt, 32'd0);
            chk("rst_valid", {31'b0, out_valid}, 32'd0);
        end

        // Release between edges; first edge after release produces a result.
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(32'd2);
        @(posedge clk);
        #1;
        check_out("rel_pop33");

        req("pop33", 1'b1, OP_POP, 32'd33);
        chk("pop33_const", cnt, 32'd2);
        req("clz33", 1'b1, OP_CLZ, 32'd33);
        chk("clz33_const", cnt, 32'd26);
        req("ctz33", 1'b1, OP_CTZ, 32'd33);
        chk("ctz33_const", cnt, 32'd0);
        req("clo33", 1'b1, OP_CLO, 32'd33);
        chk("clo33_const", cnt, 32'd0);
        req("idle0", 1'b0, OP_POP, 32'hDEAD_BEEF);

        req("pop0", 1'b1, OP_POP, 32'h0000_0000);
        req("clz0", 1'b1, OP_CLZ, 32'h0000_0000);
        chk("clz0_const", cnt, 32'd32);
        req("ctz0", 1'b1, OP_CTZ, 32'h0000_0000);
        chk("ctz0_const", cnt, 32'd32);
        req("clo0", 1'b1, OP_CLO, 32'h0000_0000);
        req("pop1s", 1'b1, OP_POP, 32'hFFFF_FFFF);
        chk("pop1s_const", cnt, 32'd32);
        req("clz1s", 1'b1, OP_CLZ, 32'hFFFF_FFFF);
        req("ctz1s", 1'b1, OP_CTZ, 32'hFFFF_FFFF);
        req("clo1s", 1'b1, OP_CLO, 32'hFFFF_FFFF);
        chk("clo1s_const", cnt, 32'd32);

        req("clz_msb", 1'b1, OP_CLZ, 32'h8000_0000);
        req("ctz_msb", 1'b1, OP_CTZ, 32'h8000_0000);
        chk("ctz_msb_const", cnt, 32'd31);
        req("clo_msb", 1'b1, OP_CLO, 32'h8000_0000);
        req("clz_lsb", 1'b1, OP_CLZ, 32'h0000_0001);
        chk("clz_lsb_const", cnt, 32'd31);
        req("ctz_lsb", 1'b1, OP_CTZ, 32'h0000_0001);
        req("pop_lsb", 1'b1, OP_POP, 32'h0000_0001);
        req("clo_f0", 1'b1, OP_CLO, 32'hF000_0000);
        chk("clo_f0_const", cnt, 32'd4);

        // Streaming then idle hold.
        req("str0", 1'b1, OP_POP, 32'h0000_000F);
        req("str1", 1'b1, OP_POP, 32'h0000_00FF);
        req("str2", 1'b1, OP_POP, 32'h0000_FFFF);
        chk("str2_const", cnt, 32'd16);
        req("str3", 1'b1, OP_POP, 32'h0000_0033);
        req("str_idle", 1'b0, OP_POP, 32'h1234_5678);
        chk("str_hold_const", cnt, 32'd4);
        req("str_idle2", 1'b0, OP_CLZ, 32'h0);

        // Random mix against the model.
        for (int k = 0; k < 20; k++) begin
            req("rand", 1'b1, 2'($urandom_range(0, 3)), $urandom);
        end

        // Async reset between edges while out_valid is high.
        req("pre_rst", 1'b1, OP_POP, 32'h0000_00FF);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_cnt", cnt, 32'd0);
        chk("async_valid", {31'b0, out_valid}, 32'd0);
        exp_q.delete();
        last_cnt = 32'd0;
        @(negedge clk);
        reset_n = 1'b1;
        req("post_rst_idle", 1'b0, OP_POP, 32'h0);
        req("post_rst", 1'b1, OP_CTZ, 32'h0000_0100);
        chk("post_rst_const", cnt, 32'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
